// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//   Receive-side checker for a slow divided clock. clk_in is synchronised into
//   the clk2 domain, and its rising edges are detected. The time between edges
//   is counted in clk2 cycles. The monitor declares lock after LOCK_CNT
//   consecutive periods that fall within EXP_PERIOD +/- TOL. It declares a
//   sticky fault when a locked period falls outside that window.
//
//   Optional build macro: CLKMON_TIMEOUT_EN adds a stuck-clock watchdog. While
//   in MEASURE, or in LOCKED, a count of EXP_PERIOD+TOL+1 with no edge
//   seen is treated as a bad period right away.
//
// Ports
//   clk2        in   fast reference clock
//   rst_n2      in   asynchronous active-low reset
//   clk_in      in   slow clock under test (asynchronous to clk2)
//   en          in   monitor enable; low forces IDLE
//   fault_clr   in   single-cycle pulse; leaves FAULT for ARM
//   edge_o      out  single-cycle pulse per detected clk_in rising edge
//   period_o    out  last measured period in clk2 cycles
//   period_vld  out  single-cycle pulse when period_o updates
//   locked      out  high in LOCKED
//   fault       out  high in FAULT
module clk_period_monitor #(
  parameter int EXP_PERIOD = 4000002,
  parameter int TOL        = 16,
  parameter int LOCK_CNT   = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk2,
  input  logic             rst_n2,
  input  logic             clk_in,
  input  logic             en,
  input  logic             fault_clr,
  output logic             edge_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld,
  output logic             locked,
  output logic             fault
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_MEAS  = 3'd2;
  localparam logic [2:0] ST_LOCK  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  // Window bounds carry one extra bit. This way a low bound that would go
  // negative clamps to zero, and a high bound above the counter range stays
  // representable.
  localparam logic [CNT_W:0] WIN_LO = (EXP_PERIOD > TOL) ? (CNT_W+1)'(EXP_PERIOD - TOL) : '0;
  localparam logic [CNT_W:0] WIN_HI = (CNT_W+1)'(EXP_PERIOD + TOL);
`ifdef CLKMON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_CNT = CNT_W'(EXP_PERIOD + TOL + 1);
`endif

  logic [2:0]       state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       good_cnt;
  logic             rise;
  logic             cnt_sat;
  logic             in_win;
  logic [CNT_W-1:0] cnt_inc;

  assign rise    = s2 & ~s3;
  assign cnt_sat = &cnt;
  assign cnt_inc = cnt_sat ? cnt : cnt + 1'b1;
  // A saturated count is an unknown-length period, so it never qualifies.
  assign in_win  = !cnt_sat && ({1'b0, cnt} >= WIN_LO) && ({1'b0, cnt} <= WIN_HI);

  assign locked = (state == ST_LOCK);
  assign fault  = (state == ST_FAULT);

  always_ff @(posedge clk2 or negedge rst_n2) begin
    if (!rst_n2) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
      good_cnt   <= '0;
      edge_o     <= 1'b0;
      period_o   <= '0;
      period_vld <= 1'b0;
    end else begin
      // The synchroniser keeps running while the monitor is disabled.
      // Because of that, enabling the monitor never produces a false edge.
      s1         <= clk_in;
      s2         <= s1;
      s3         <= s2;
      edge_o     <= 1'b0;
      period_vld <= 1'b0;
      if (!en) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        good_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARM;
          ST_ARM: begin
            // The first edge only starts timing. The partial period before it is dropped.
            if (rise) begin
              state    <= ST_MEAS;
              cnt      <= CNT_W'(1);
              good_cnt <= '0;
              edge_o   <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_MEAS, ST_LOCK, ST_FAULT: begin
            if (state == ST_FAULT && fault_clr) begin
              // Clear wins over a coincident edge. That edge is not used to re-arm.
              state    <= ST_ARM;
              cnt      <= '0;
              good_cnt <= '0;
              edge_o   <= rise;
            end else if (rise) begin
              edge_o     <= 1'b1;
              period_o   <= cnt;
              period_vld <= 1'b1;
              cnt        <= CNT_W'(1);
              if (state == ST_MEAS) begin
                if (in_win) begin
                  good_cnt <= good_cnt + 1'b1;
                  if (good_cnt + 4'd1 == 4'(LOCK_CNT)) state <= ST_LOCK;
                end else begin
                  good_cnt <= '0;
                end
              end else if (state == ST_LOCK && !in_win) begin
                state    <= ST_FAULT;
                good_cnt <= '0;
              end
            end else begin
              cnt <= cnt_inc;
`ifdef CLKMON_TIMEOUT_EN
              // Stuck-clock watchdog: the period is already too long to be good.
              if (cnt == WD_CNT) begin
                if (state == ST_MEAS) good_cnt <= '0;
                if (state == ST_LOCK) begin
                  state    <= ST_FAULT;
                  good_cnt <= '0;
                end
              end
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
